// File: rtl/alert_queue.sv
// Alert FIFO: captures validated instruction pulses, suppresses repeats inside a
// hold-off window, stamps sequence numbers and drains over a valid/ready handshake.
module alert_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned HOLDOFF = 16,
  parameter int unsigned SEQ_W   = 12
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic             in_valid,
  input  logic [63:0]      in_ins,
  input  logic [15:0]      in_check,
  input  logic             alert_ready,
  input  logic             clr_ovf,
  output logic             alert_valid,
  output logic [63:0]      alert_ins,
  output logic [15:0]      alert_check,
  output logic [SEQ_W-1:0] alert_seq,
  output logic [AW:0]      level,
  output logic             ovf,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned HW = $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HoldReload = HW'(HOLDOFF);
  localparam logic [AW:0]   LevelFull  = (AW + 1)'(DEPTH);

  logic [63:0]      ins_mem_q [DEPTH];
  logic [15:0]      chk_mem_q [DEPTH];
  logic [SEQ_W-1:0] seq_mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [63:0]      last_ins_q, last_ins_d;
  logic             last_vld_q, last_vld_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic pop, is_data, is_dup, is_ovf, do_wr;

  always_comb begin
    pop     = (level_q != '0) && alert_ready;
    is_data = in_valid && (in_ins != 64'd0);
    is_dup  = is_data && last_vld_q && (in_ins == last_ins_q) && (hold_cnt_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO only overflows without one.
    is_ovf  = is_data && !is_dup && (level_q == LevelFull) && !pop;
    do_wr   = is_data && !is_dup && !is_ovf;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    seq_d      = seq_q;
    last_ins_d = last_ins_q;
    last_vld_d = last_vld_q;
    hold_cnt_d = hold_cnt_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (do_wr) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      seq_d      = seq_q + 1'b1;
      last_ins_d = in_ins;
      last_vld_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({do_wr, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (do_wr || is_dup) begin
      hold_cnt_d = HoldReload;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
    end

    if ((is_dup || is_ovf) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end

    // Set beats clear when both happen in one cycle.
    if (is_ovf) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      seq_q      <= '0;
      last_ins_q <= '0;
      last_vld_q <= 1'b0;
      hold_cnt_q <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      seq_q      <= seq_d;
      last_ins_q <= last_ins_d;
      last_vld_q <= last_vld_d;
      hold_cnt_q <= hold_cnt_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: outputs are masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      ins_mem_q[wr_ptr_q] <= in_ins;
      chk_mem_q[wr_ptr_q] <= in_check;
      seq_mem_q[wr_ptr_q] <= seq_q;
    end
  end

  always_comb begin
    alert_valid = (level_q != '0);
    alert_ins   = alert_valid ? ins_mem_q[rd_ptr_q] : '0;
    alert_check = alert_valid ? chk_mem_q[rd_ptr_q] : '0;
    alert_seq   = alert_valid ? seq_mem_q[rd_ptr_q] : '0;
    level       = level_q;
    ovf         = ovf_q;
    drop_cnt    = drop_cnt_q;
  end

endmodule

// File: tb/tb_alert_queue.sv
// Directed bench for alert_queue: hand-computed expectations for capture, hold-off
// suppression, overflow, full-with-pop, nodata pulses and asynchronous reset.
module tb_alert_queue;

  logic        clk = 1'b0;
  logic        RST_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_ins = '0;
  logic [15:0] in_check = '0;
  logic        alert_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        alert_valid;
  logic [63:0] alert_ins;
  logic [15:0] alert_check;
  logic [11:0] alert_seq;
  logic [3:0]  level;
  logic        ovf;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  alert_queue #(
    .DEPTH  (8),
    .AW     (3),
    .HOLDOFF(16),
    .SEQ_W  (12)
  ) u_dut (
    .clk        (clk),
    .RST_n      (RST_n),
    .in_valid   (in_valid),
    .in_ins     (in_ins),
    .in_check   (in_check),
    .alert_ready(alert_ready),
    .clr_ovf    (clr_ovf),
    .alert_valid(alert_valid),
    .alert_ins  (alert_ins),
    .alert_check(alert_check),
    .alert_seq  (alert_seq),
    .level      (level),
    .ovf        (ovf),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [63:0] ins, input logic [15:0] chk);
    in_valid = 1'b1;
    in_ins   = ins;
    in_check = chk;
    step();
    in_valid = 1'b0;
    in_ins   = '0;
    in_check = '0;
  endtask

  task automatic do_reset();
    #2;
    RST_n = 1'b0;
    #2;
    RST_n = 1'b1;
    step();
  endtask

  initial begin
    // Basic capture and handshake
    do_reset();
    check_eq("rst_valid", 64'(alert_valid), 64'd0);
    check_eq("rst_level", 64'(level), 64'd0);
    check_eq("rst_ins", alert_ins, 64'd0);
    check_eq("rst_drop", 64'(drop_cnt), 64'd0);
    pulse(64'hA5, 16'h1234);
    check_eq("t1_valid", 64'(alert_valid), 64'd1);
    check_eq("t1_ins", alert_ins, 64'hA5);
    check_eq("t1_check", 64'(alert_check), 64'h1234);
    check_eq("t1_seq", 64'(alert_seq), 64'd0);
    check_eq("t1_level", 64'(level), 64'd1);
    step();
    check_eq("t1_hold_ins", alert_ins, 64'hA5);
    alert_ready = 1'b1;
    step();
    alert_ready = 1'b0;
    check_eq("t1_pop_valid", 64'(alert_valid), 64'd0);
    check_eq("t1_pop_level", 64'(level), 64'd0);
    check_eq("t1_pop_ins", alert_ins, 64'd0);

    // Hold-off duplicate suppression
    do_reset();
    pulse(64'h7, 16'h0007);
    repeat (4) step();
    pulse(64'h7, 16'h0007);
    check_eq("t2_drop", 64'(drop_cnt), 64'd1);
    check_eq("t2_level", 64'(level), 64'd1);
    repeat (24) step();
    pulse(64'h7, 16'h0077);
    check_eq("t2_late_level", 64'(level), 64'd2);
    check_eq("t2_late_drop", 64'(drop_cnt), 64'd1);
    alert_ready = 1'b1;
    step();
    alert_ready = 1'b0;
    check_eq("t2_late_seq", 64'(alert_seq), 64'd1);
    check_eq("t2_late_chk", 64'(alert_check), 64'h0077);

    // Overflow and in-order drain
    do_reset();
    for (int i = 1; i <= 9; i++) pulse(64'(i), 16'(16'h100 + i));
    check_eq("t3_level", 64'(level), 64'd8);
    check_eq("t3_ovf", 64'(ovf), 64'd1);
    check_eq("t3_drop", 64'(drop_cnt), 64'd1);
    alert_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("t3_seq%0d", k), 64'(alert_seq), 64'(k));
      check_eq($sformatf("t3_ins%0d", k), alert_ins, 64'(k + 1));
      step();
    end
    alert_ready = 1'b0;
    check_eq("t3_empty", 64'(alert_valid), 64'd0);
    check_eq("t3_ovf_sticky", 64'(ovf), 64'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check_eq("t3_ovf_clr", 64'(ovf), 64'd0);

    // Full with simultaneous pop, then set-beats-clear
    do_reset();
    for (int i = 0; i < 8; i++) pulse(64'(16 + i), 16'(i));
    alert_ready = 1'b1;
    pulse(64'h99, 16'h0099);
    alert_ready = 1'b0;
    check_eq("t4_level", 64'(level), 64'd8);
    check_eq("t4_ovf", 64'(ovf), 64'd0);
    check_eq("t4_drop", 64'(drop_cnt), 64'd0);
    check_eq("t4_head_seq", 64'(alert_seq), 64'd1);
    check_eq("t4_head_ins", alert_ins, 64'h11);
    clr_ovf = 1'b1;
    pulse(64'hAA, 16'h00AA);
    clr_ovf = 1'b0;
    check_eq("t4_set_wins", 64'(ovf), 64'd1);
    check_eq("t4_drop2", 64'(drop_cnt), 64'd1);
    alert_ready = 1'b1;
    repeat (7) step();
    alert_ready = 1'b0;
    check_eq("t4_last_ins", alert_ins, 64'h99);
    check_eq("t4_last_seq", 64'(alert_seq), 64'd8);

    // Nodata pulses leave level, drop count and sequence untouched
    repeat (3) pulse(64'd0, 16'hFFFF);
    check_eq("t5_level", 64'(level), 64'd1);
    check_eq("t5_drop", 64'(drop_cnt), 64'd1);
    pulse(64'hBB, 16'h00BB);
    alert_ready = 1'b1;
    step();
    alert_ready = 1'b0;
    check_eq("t5_ins", alert_ins, 64'hBB);
    check_eq("t5_seq", 64'(alert_seq), 64'd9);

    // Asynchronous reset mid-drain
    do_reset();
    pulse(64'h21, 16'h0021);
    pulse(64'h21, 16'h0021);
    pulse(64'h22, 16'h0022);
    pulse(64'h23, 16'h0023);
    pulse(64'h24, 16'h0024);
    check_eq("t6_pre_level", 64'(level), 64'd4);
    check_eq("t6_pre_drop", 64'(drop_cnt), 64'd1);
    alert_ready = 1'b1;
    step();
    #2;
    RST_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 64'(alert_valid), 64'd0);
    check_eq("t6_rst_level", 64'(level), 64'd0);
    check_eq("t6_rst_drop", 64'(drop_cnt), 64'd0);
    alert_ready = 1'b0;
    RST_n = 1'b1;
    step();
    pulse(64'h55, 16'h0055);
    check_eq("t6_new_seq", 64'(alert_seq), 64'd0);
    check_eq("t6_new_ins", alert_ins, 64'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alert_queue.md
Name: alert_queue

Overview:
- Downstream of the instruction index/check stage.
- Captures each validated instruction pulse (64-bit instruction plus 16-bit check word) into a small FIFO.
- Suppresses repeated alerts for the same instruction within a hold-off window, stamps each stored entry with a sequence number, and drains entries to the alert reporter over a valid/ready handshake.
- Flags overflow and counts every dropped pulse.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- AW, 3: log2(DEPTH).
- HOLDOFF, 16: cycles during which a repeat of the last stored instruction is dropped; at least 1.
- SEQ_W, 12: sequence-number width.

Ports:
- clk  in  1  single clock, rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  one-cycle pulse: in_ins/in_check are valid (driven from the index stage's out).
- in_ins  in  64  validated instruction.
- in_check  in  16  check word paired with in_ins.
- alert_ready  in  1  consumer accepts the head entry.
- clr_ovf  in  1  clears the sticky overflow flag.
- alert_valid  out  1  head entry present.
- alert_ins  out  64  head instruction.
- alert_check  out  16  head check word.
- alert_seq  out  SEQ_W  head sequence number.
- level  out  AW+1  entries held, 0..DEPTH.
- ovf  out  1  sticky overflow.
- drop_cnt  out  8  dropped pulses (duplicates plus overflows), saturating.

Behaviour:
- Reset, asynchronous: all outputs 0; FIFO pointers 0; seq counter 0; last_ins 0; last_vld 0; hold_cnt 0. Reset mid-operation discards all content immediately.
- Upstream has no backpressure. Every in_valid pulse is evaluated in the cycle it arrives.
- Classification of a cycle with in_valid=1, first match wins:
  1. in_ins==64'd0 (nodata): ignored. No write, no count, no state change.
  2. Duplicate: last_vld=1, in_ins==last_ins and hold_cnt!=0. Dropped; drop_cnt+1; hold_cnt reloads HOLDOFF.
  3. Overflow: level==DEPTH and no pop this cycle. Dropped; drop_cnt+1; ovf<=1. last_ins and hold_cnt unchanged.
  4. Otherwise write. The entry {in_ins, in_check, seq} is stored at the write pointer; seq+1 (wraps mod 2^SEQ_W); last_ins<=in_ins; last_vld<=1; hold_cnt<=HOLDOFF.
- hold_cnt decrements by 1 per cycle when non-zero and not reloaded.
- Pop occurs when alert_valid and alert_ready are both 1. The read pointer advances.
- Full with simultaneous pop: the write is allowed and level stays DEPTH.
- Empty with a write: no bypass. alert_valid rises at the edge that stores the entry (1-cycle latency); pop is possible from the following cycle.
- Output is first-word-fall-through. alert_valid = (level!=0). While alert_valid=1 and alert_ready=0, alert_ins/alert_check/alert_seq are held stable. When alert_valid=0, alert_ins/alert_check/alert_seq read 0.
- level: +1 on write only, -1 on pop only, unchanged on both.
- Pointers are AW bits and wrap naturally.
- ovf: sticky. clr_ovf=1 clears it; if set and clear occur in the same cycle, set wins.
- drop_cnt: saturates at 255; cleared only by reset.
- A duplicate arriving after the hold-off window expires (hold_cnt==0) is written normally.

Test Plan:
- Reset, then in_valid with in_ins=64'hA5, in_check=16'h1234, alert_ready=0 → next cycle: alert_valid=1, alert_ins=64'hA5, alert_check=16'h1234, alert_seq=0, level=1. Holds until alert_ready=1, then alert_valid=0 and level=0.
- With HOLDOFF=16: pulse 64'h7 at cycle 0 and again at cycle 5 → second pulse dropped, drop_cnt=1, level=1. Pulse 64'h7 at cycle 30 → written with seq=1.
- alert_ready=0; 9 distinct non-zero pulses (DEPTH=8) → level=8, ovf=1, drop_cnt=1. Drain → seqs 0..7 in order. clr_ovf → ovf=0.
- Full FIFO, alert_ready=1, and a new pulse in the same cycle → write accepted, level stays 8, ovf stays 0.
- in_ins=0 pulses → no change to level, drop_cnt, or seq.
- 4 entries stored, RST_n low mid-drain → asynchronously: alert_valid=0, level=0, drop_cnt=0. Next write gets seq=0.
